sort_sequencer: RTL and testbench

Buffered ascending sorter that owns a single N-bit magnitude comparator and time-shares it across a DEPTH-entry register file. It accepts a frame of DEPTH words over a valid/ready input and runs a fixed-length bubble sort, issuing one comparison per cycle. It then streams the sorted frame out over a valid/ready output. It sits between a word producer and any consumer that needs ordered data (min/max selection, median pick), and reuses the existing comparator rather than building a parallel sorting network.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/sort_sequencer_cmp.sv | 16 +
 rtl/sort_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_sort_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and width helpers for the time-shared bubble sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SWAP_W    = 8;
  localparam int DEPTH_DEF = 4;

  // Width of a word index into a DEPTH-entry buffer (never narrower than 1 bit).
  function automatic int idx_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Width of the pass counter, which only has to reach DEPTH-2.
  function automatic int pass_width(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

  localparam int IDX_W  = idx_width(DEPTH_DEF);
  localparam int PASS_W = pass_width(DEPTH_DEF);

endpackage

// File: rtl/sort_sequencer_cmp.sv
// Parameterised unsigned magnitude comparator shared by the sorter datapath.
module mag_cmp #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         is_small,
  output logic         is_equal,
  output logic         is_greater
);

  assign is_small   = (a < b);
  assign is_equal   = (a == b);
  assign is_greater = (a > b);

endmodule

// File: rtl/sort_sequencer.sv
// Buffered ascending sorter: fill DEPTH words, bubble-sort them with one shared
// comparator (one compare per cycle, fixed length), then stream them out.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic              busy,
  output logic [SWAP_W-1:0] swaps
);

  localparam int IW = idx_width(DEPTH);
  localparam int PW = pass_width(DEPTH);

  localparam logic [IW-1:0]     LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0]     LAST_I    = IW'(DEPTH - 2);
  localparam logic [PW-1:0]     LAST_PASS = PW'(DEPTH - 2);
  localparam logic [SWAP_W-1:0] SWAP_MAX  = {SWAP_W{1'b1}};

  state_e              state_r;
  state_e              next_state_s;
  logic [N-1:0]        mem_r [DEPTH];
  logic [IW-1:0]       wr_idx_r;
  logic [IW-1:0]       rd_idx_r;
  logic [IW-1:0]       i_r;
  logic [IW-1:0]       i_nxt_s;
  logic [PW-1:0]       pass_r;
  logic [SWAP_W-1:0]   swaps_r;
  logic [N-1:0]        a_s;
  logic [N-1:0]        b_s;
  logic                is_greater_s;
  logic                accept_s;
  logic                last_acc_s;
  logic                last_cmp_s;
  logic                out_fire_s;
  logic                last_out_s;
  logic                swap_s;

  assign i_nxt_s = i_r + IW'(1);
  assign a_s     = mem_r[i_r];
  assign b_s     = mem_r[i_nxt_s];

  mag_cmp #(.N(N)) u_cmp (
    .a          (a_s),
    .b          (b_s),
    .is_small   (),
    .is_equal   (),
    .is_greater (is_greater_s)
  );

  // Handshake and sequencing events, all derived from registered state.
  assign accept_s   = (state_r == LOAD) && in_valid;
  assign last_acc_s = accept_s && (wr_idx_r == LAST_IDX);
  assign last_cmp_s = (state_r == SORT) && (i_r == LAST_I) && (pass_r == LAST_PASS);
  assign out_fire_s = (state_r == DRAIN) && out_ready;
  assign last_out_s = out_fire_s && (rd_idx_r == LAST_IDX);
  assign swap_s     = (state_r == SORT) && is_greater_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LOAD: begin
        if (last_acc_s) begin
          next_state_s = SORT;
        end else begin
          next_state_s = LOAD;
        end
      end
      SORT: begin
        if (last_cmp_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = SORT;
        end
      end
      DRAIN: begin
        if (last_out_s) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: begin
        next_state_s = LOAD;
      end
    endcase
  end

  // Outputs decoded from state only; out_data reads the buffer at the registered rd_idx.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = {N{1'b0}};
    case (state_r)
      LOAD: begin
        in_ready = ~rst;
      end
      SORT: begin
        busy = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = mem_r[rd_idx_r];
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign swaps = swaps_r;

  // Word buffer: written on accept during fill, pairwise exchanged during the sort.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {N{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[wr_idx_r] <= in_data;
    end else if (swap_s) begin
      mem_r[i_r]     <= b_s;
      mem_r[i_nxt_s] <= a_s;
    end
  end

  // Fill index: one step per accepted word, rewound once the frame is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_r <= {IW{1'b0}};
    end else if (last_acc_s || last_out_s) begin
      wr_idx_r <= {IW{1'b0}};
    end else if (accept_s) begin
      wr_idx_r <= wr_idx_r + IW'(1);
    end
  end

  // Compare position and pass counters; no early exit, so SORT length is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r    <= {IW{1'b0}};
      pass_r <= {PW{1'b0}};
    end else if (last_acc_s) begin
      i_r    <= {IW{1'b0}};
      pass_r <= {PW{1'b0}};
    end else if (state_r == SORT) begin
      if (i_r == LAST_I) begin
        i_r    <= {IW{1'b0}};
        pass_r <= last_cmp_s ? {PW{1'b0}} : pass_r + PW'(1);
      end else begin
        i_r    <= i_nxt_s;
      end
    end
  end

  // Swap counter: cleared when a sort starts, held after it ends, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      swaps_r <= {SWAP_W{1'b0}};
    end else if (last_acc_s) begin
      swaps_r <= {SWAP_W{1'b0}};
    end else if (swap_s && (swaps_r != SWAP_MAX)) begin
      swaps_r <= swaps_r + 8'd1;
    end
  end

  // Drain index: only moves on an output handshake, so a stalled consumer sees stable data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_r <= {IW{1'b0}};
    end else if (last_cmp_s || last_out_s) begin
      rd_idx_r <= {IW{1'b0}};
    end else if (out_fire_s) begin
      rd_idx_r <= rd_idx_r + IW'(1);
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer (N=4, DEPTH=4) against a stable-sort/inversion-count model.
module tb_sort_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic [7:0] swaps;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  bit b2b_pending = 1'b0;
  logic [3:0] frame_v [4];

  sort_sequencer #(.N(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .swaps     (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: stable ascending order; bubble-sort swap count equals the inversion count.
  task automatic ref_sort(input logic [3:0] w [4], output logic [3:0] s [4], output int inv);
    int q[$];
    int p;
    inv = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (w[i] > w[j]) inv++;
    q = {};
    for (int i = 0; i < 4; i++) begin
      p = q.size();
      while (p > 0 && q[p-1] > int'(w[i])) p--;
      q.insert(p, int'(w[i]));
    end
    for (int i = 0; i < 4; i++) s[i] = 4'(q[i]);
  endtask

  // vmode: 0 = in_valid always high, 1 = toggling 1,0,1,..., 2 = random gaps.
  task automatic do_frame(input logic [3:0] w [4], input int vmode, input int rgap,
                          input int hold0, input bit keep_valid);
    logic [3:0] exp_s [4];
    int exp_sw, n_in, n_out, acc_cyc, first_valid, hold_cnt, guard;
    bit tog, chk_b2b;
    ref_sort(w, exp_s, exp_sw);
    n_in = 0; n_out = 0; acc_cyc = -1; first_valid = -1; hold_cnt = 0; guard = 0;
    tog = 1'b1;
    chk_b2b = b2b_pending;
    b2b_pending = 1'b0;
    while (n_out < 4 && guard < 300) begin
      guard++;
      @(posedge clk); #1;
      if (n_in < 4) begin
        case (vmode)
          0: in_valid = 1'b1;
          1: begin in_valid = tog; tog = ~tog; end
          default: in_valid = ($urandom_range(0, 99) >= 30);
        endcase
        in_data = w[n_in];
      end else begin
        in_valid = keep_valid;
        in_data  = 4'($urandom_range(0, 15));
      end
      out_ready = (hold_cnt < hold0) ? 1'b0 : ($urandom_range(0, 99) >= rgap);
      @(negedge clk);
      if (n_in < 4) begin
        check_eq("load_in_ready", int'(in_ready), 1);
        check_eq("load_busy", int'(busy), 0);
        check_eq("load_out_valid", int'(out_valid), 0);
      end else begin
        check_eq("busy_high", int'(busy), 1);
        check_eq("in_ready_low", int'(in_ready), 0);
      end
      if (out_valid && hold_cnt < hold0) begin
        check_eq("hold_data", int'(out_data), int'(exp_s[0]));
        hold_cnt++;
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        check_eq("latency", first_valid - acc_cyc, 10);
      end
      if (out_valid && out_ready) begin
        check_eq("out_word", int'(out_data), int'(exp_s[n_out]));
        n_out++;
        if (n_out == 4) last_hs_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (n_in == 0 && chk_b2b) check_eq("b2b_first_accept", cyc, last_hs_cyc + 1);
        n_in++;
        if (n_in == 4) acc_cyc = cyc;
      end
    end
    check_eq("frame_done", n_out, 4);
    check_eq("swaps", int'(swaps), exp_sw);
    b2b_pending = keep_valid;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_swaps", int'(swaps), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", int'(in_ready), 1);

    frame_v = '{4'd9, 4'd3, 4'd12, 4'd3};
    do_frame(frame_v, 0, 0, 0, 1'b0);
    frame_v = '{4'd1, 4'd2, 4'd3, 4'd4};
    do_frame(frame_v, 0, 0, 0, 1'b0);
    frame_v = '{4'd15, 4'd10, 4'd5, 4'd0};
    do_frame(frame_v, 0, 0, 3, 1'b0);

    // Reset in the 4th SORT cycle discards the frame.
    frame_v = '{4'd15, 4'd10, 4'd5, 4'd0};
    n = 0; guard = 0;
    while (n < 4 && guard < 50) begin
      guard++;
      @(posedge clk); #1 in_valid = 1'b1; in_data = frame_v[n];
      @(negedge clk);
      if (in_valid && in_ready) n++;
    end
    check_eq("rst_frame_loaded", n, 4);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 4'd1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("mid_sort_swaps", int'(swaps), 3);
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", int'(in_ready), 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_swaps", int'(swaps), 0);
    frame_v = '{4'd7, 4'd7, 4'd2, 4'd8};
    do_frame(frame_v, 1, 0, 0, 1'b0);

    // Back-to-back frames with in_valid held high.
    frame_v = '{4'd6, 4'd14, 4'd0, 4'd9};
    do_frame(frame_v, 0, 0, 0, 1'b1);
    frame_v = '{4'd11, 4'd11, 4'd3, 4'd5};
    do_frame(frame_v, 0, 0, 0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 4; k++) frame_v[k] = 4'($urandom_range(0, 15));
      do_frame(frame_v, 2, 30, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
